// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame levels, default timing
// and the receiver state encoding.
package uart_rx_pkg;

    localparam int   DEF_CLKS_PER_BIT = 434;
    localparam int   DEF_DATA_BITS    = 8;
    localparam logic START_LEVEL      = 1'b0;
    localparam logic STOP_LEVEL       = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous line, with a delayed copy for
// falling-edge detection; reusable for any idle-high async input.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic       meta;
    logic       level_d;
    logic [1:0] warm;

    // The warm-up count masks the edge that would appear when a line held low
    // out of reset flushes the high reset values through the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            warm    <= 2'd0;
        end else begin
            meta    <= din;
            level   <= meta;
            level_d <= level;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign fall = (warm == 2'd3) && level_d && !level;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from an internal bit timer, byte output
// on a valid/ready handshake with framing and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int   CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int   DATA_BITS    = DEF_DATA_BITS,
    parameter logic STOP_BIT     = STOP_LEVEL
) (
    input  logic                 RST_clk,
    input  logic                 RST,
    input  logic                 uart_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 rx_overrun,
    output logic                 uart_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state, state_next;
    logic [CW-1:0]        clk_cnt, clk_cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 new_byte;
    logic                 stop_bad;
    logic                 rx_s;
    logic                 rx_fall;

    uart_rx_sync u_sync (
        .clk   (RST_clk),
        .rst   (RST),
        .din   (uart_rx_data),
        .level (rx_s),
        .fall  (rx_fall)
    );

    // The STOP state hands back to IDLE at mid stop bit so a following start
    // edge immediately after the stop bit is still seen.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt + CW'(1);
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        new_byte     = 1'b0;
        stop_bad     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt == HALF_LAST) begin
                    state_next   = (rx_s == START_LEVEL) ? ST_DATA : ST_IDLE;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    shreg_next   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + BW'(1);
                    clk_cnt_next = '0;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    state_next = ST_IDLE;
                    if (rx_s == STOP_BIT) begin
                        new_byte = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state || state == ST_IDLE) begin
            clk_cnt_next = '0;
        end

        data_next  = new_byte ? shreg : rx_data;
        valid_next = new_byte | (rx_valid & ~rx_ready);
    end

    always_ff @(posedge RST_clk) begin
        if (RST) begin
            state      <= ST_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            uart_busy  <= 1'b0;
        end else begin
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            rx_data    <= data_next;
            rx_valid   <= valid_next;
            frame_err  <= stop_bad;
            rx_overrun <= new_byte & rx_valid & ~rx_ready;
            uart_busy  <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: normal bytes, back-to-back
// frames, framing error, start glitch, overrun and reset mid-frame.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_overrun;
    logic       uart_busy;

    int tests_run  = 0;
    int fail_count = 0;

    logic [7:0] accepted[$];
    int fe_cycles   = 0;
    int ov_cycles   = 0;
    int busy_cycles = 0;
    int rd_idx      = 0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BIT     (1'b1)
    ) dut (
        .RST_clk      (clk),
        .RST          (rst),
        .uart_rx_data (line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (ready),
        .frame_err    (frame_err),
        .rx_overrun   (rx_overrun),
        .uart_busy    (uart_busy)
    );

    always #5 clk = ~clk;

    // Observe handshakes and pulses mid-cycle, when inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && ready) accepted.push_back(rx_data);
            if (frame_err)  fe_cycles++;
            if (rx_overrun) ov_cycles++;
            if (uart_busy)  busy_cycles++;
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int idx);
        if (idx < accepted.size()) return {24'd0, accepted[idx]};
        return 32'hDEAD;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            tick(CPB);
        end
        line = stop;
        tick(CPB);
        line = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'd0, rx_data}, 32'h0);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'h0);
        check({tag, "_ferr"},  {31'd0, frame_err}, 32'h0);
        check({tag, "_ovr"},   {31'd0, rx_overrun}, 32'h0);
        check({tag, "_busy"},  {31'd0, uart_busy}, 32'h0);
    endtask

    initial begin
        int busy_before;

        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(10);

        // 1: single byte, held until consumed
        send_byte(8'hA5, 1'b1);
        tick(2);
        check("t1_data",  {24'd0, rx_data}, 32'hA5);
        check("t1_valid", {31'd0, rx_valid}, 32'h1);
        tick(5);
        check("t1_hold",  {31'd0, rx_valid}, 32'h1);
        check("t1_ferr",  fe_cycles, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("t1_clear", {31'd0, rx_valid}, 32'h0);
        check("t1_acc_n", accepted.size(), 1);
        check("t1_acc",   acc_at(rd_idx), 32'hA5);
        rd_idx = accepted.size();

        // 2: back-to-back frames with consumer always ready
        ready = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(5);
        check("t2_acc_n", accepted.size() - rd_idx, 2);
        check("t2_acc0",  acc_at(rd_idx), 32'h00);
        check("t2_acc1",  acc_at(rd_idx + 1), 32'hFF);
        check("t2_valid", {31'd0, rx_valid}, 32'h0);
        check("t2_ferr",  fe_cycles, 0);
        check("t2_ovr",   ov_cycles, 0);
        rd_idx = accepted.size();
        ready = 1'b0;

        // 3: bad stop bit
        send_byte(8'h3C, 1'b0);
        tick(10);
        check("t3_ferr",  fe_cycles, 1);
        check("t3_valid", {31'd0, rx_valid}, 32'h0);
        check("t3_acc_n", accepted.size() - rd_idx, 0);

        // 4: short low glitch on the idle line
        busy_before = busy_cycles;
        line = 1'b0;
        tick(4);
        line = 1'b1;
        tick(30);
        check("t4_busy_seen", {31'd0, busy_cycles > busy_before}, 32'h1);
        check("t4_busy_end",  {31'd0, uart_busy}, 32'h0);
        check("t4_valid",     {31'd0, rx_valid}, 32'h0);
        check("t4_ferr",      fe_cycles, 1);
        check("t4_ovr",       ov_cycles, 0);

        // 5: second byte overwrites an unconsumed first byte
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(2);
        check("t5_data",  {24'd0, rx_data}, 32'h22);
        check("t5_valid", {31'd0, rx_valid}, 32'h1);
        check("t5_ovr",   ov_cycles, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("t5_acc_n", accepted.size() - rd_idx, 1);
        check("t5_acc",   acc_at(rd_idx), 32'h22);
        check("t5_clear", {31'd0, rx_valid}, 32'h0);
        rd_idx = accepted.size();

        // 6: reset during data bit 4 of 0xC3, then a clean 0x5A
        line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            line = 8'hC3 >> i;
            tick(CPB);
        end
        line = 1'b0;
        tick(CPB / 2);
        check("t6_busy_pre", {31'd0, uart_busy}, 32'h1);
        rst  = 1'b1;
        line = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        tick(2);
        rst = 1'b0;
        tick(10);
        ready = 1'b1;
        send_byte(8'h5A, 1'b1);
        tick(5);
        check("t6_acc_n", accepted.size() - rd_idx, 1);
        check("t6_acc",   acc_at(rd_idx), 32'h5A);
        check("t6_data",  {24'd0, rx_data}, 32'h5A);
        check("t6_ferr",  fe_cycles, 1);
        check("t6_ovr",   ov_cycles, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
